mmio_bus_fabric: RTL
====================

// Module: mmio_bus_fabric
// PURPOSE
//  Registered single-master -> NS-slave memory-mapped bus fabric, replacing ad-hoc testbench address decode
//  (ram / tty_tx / tty_rx muxing). It sits between a generated core's addr/size/valid/write/wdata/rdata/ready port
//  and NS slave windows. It adds an explicit request FSM, an error response for unmapped addresses and an
//  optional timeout for hung slaves.
// PARAMETERS
//  NS      4                    number of slave windows
//  AW      32                   address width
//  DW      32                   data width
//  BASE    {NS{AW'h0}}          packed NS*AW window base addresses; entry i = bits [i*AW +: AW]
//  MASK    {NS{AW'h0}}          packed NS*AW window masks; hit_i = ((addr & MASK_i) == BASE_i)
//  TMO     255                  BUSY-cycle limit before timeout (only with FABRIC_TIMEOUT_EN); range 1..65535
// PORTS
//  clk      in   1      clock, all state on posedge
//  rst      in   1      asynchronous reset, active-high
//  addr     in   AW     master byte address
//  size     in   3      master access size, passed through
//  valid    in   1      master request; held by master until ready
//  write    in   1      1 = write, 0 = read
//  wdata    in   DW     master write data
//  rdata    out  DW     read data, valid while ready=1
//  ready    out  1      one-cycle completion pulse
//  err      out  1      qualifies ready: 1 = unmapped or timed out
//  s_valid  out  NS     one-hot slave request
//  s_addr   out  AW     addr - BASE_sel, registered
//  s_size   out  3      registered size
//  s_write  out  1      registered write
//  s_wdata  out  DW     registered wdata
//  s_rdata  in   NS*DW  slave read data, packed
//  s_ready  in   NS     slave completion
// BEHAVIOUR
//  - Reset values: every output 0, state IDLE, counter 0. Reset asserted mid-transaction drops s_valid
//    immediately (async); no ready is issued.
//  - Decode: priority, lowest index wins on overlapping windows. No hit = unmapped.
//  - FSM
//    IDLE: on valid, latch addr offset / size / write / wdata / sel.
//      mapped   -> BUSY, s_valid[sel]=1 from the next cycle;
//      unmapped -> RESP with err=1, rdata=0; no slave is touched.
//    BUSY: s_valid[sel] held, s_* stable.
//      On s_ready[sel]: capture s_rdata[sel*DW +: DW] (0 on writes), drop s_valid, -> RESP.
//      s_ready on non-selected slaves is ignored.
//    RESP: ready=1 for exactly one cycle with rdata/err -> IDLE.
//      A valid present in that IDLE cycle is taken as a new request.
//  - Latency: mapped access = slave latency + 2 cycles (min 3 clocks valid -> ready, with s_ready asserted
//    the first cycle s_valid is seen). Unmapped = 2 clocks.
//  - A master dropping valid during BUSY does not abort; the slave cycle completes and ready still pulses.
//  - s_ready asserted together with the timeout expiry cycle: the slave completion wins, err=0.
//  - rdata holds its last value outside RESP; the bench checks it only when ready=1.
// CONFIGURATION
//  FABRIC_TIMEOUT_EN defined:
//    - 16-bit counter clears on IDLE->BUSY and increments each BUSY cycle.
//    - When it reaches TMO: drop s_valid, -> RESP with err=1, rdata=0.
//    - A late s_ready from that slave, arriving in RESP or IDLE, is ignored.
//  Undefined: no counter; BUSY waits indefinitely for s_ready.
// STRUCTURE
//  Package mmio_bus_pkg:
//    - state enum {IDLE, BUSY, RESP};
//    - function win_hit(addr, base, mask);
//    - default window constants RAM_BASE = 'h1000 / RAM_MASK = 'hF000,
//      STDOUT = 'h3000 / 'hFFFC, STDIN = 'h3004 / 'hFFFC.
//  One sub-module: mmio_addr_decode
//    - combinational priority encoder: addr -> sel index + hit;
//    - parametrised by NS / AW / BASE / MASK.
// TESTING
//  Configuration: NS=3, windows RAM / STDOUT / STDIN as above, TMO=8, run with and without FABRIC_TIMEOUT_EN.
//  1. Read addr='h1010, RAM slave s_ready after 2 cycles with rdata='hCAFE0001
//     -> s_addr='h010, ready pulse once with rdata='hCAFE0001, err=0.
//  2. Write addr='h3000, wdata='h41 -> only s_valid[1] asserts, s_wdata='h41, s_write=1, ready err=0.
//  3. Read addr='h5000 -> no s_valid ever, ready 2 clocks after valid, err=1, rdata=0.
//  4. TIMEOUT_EN, read 'h3004 with stdin never ready -> s_valid high exactly 8 BUSY cycles, then ready err=1.
//     Without the macro, no ready within 100 cycles.
//  5. Back-to-back: valid held across the ready cycle with a new addr='h1014
//     -> second request accepted in the following IDLE cycle, two distinct ready pulses.
//  6. rst pulsed while in BUSY -> s_valid / ready / err 0 within the reset cycle, FSM IDLE,
//     next request completes normally.

Source files
------------

// File: rtl/mmio_bus_pkg.sv
// Shared types, default window map and the window-match helper for the MMIO bus fabric.
package mmio_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  // Widest address the match helper handles; callers zero-extend into it.
  localparam int unsigned ADDR_MAX = 64;

  // Default window map of the original testbench (RAM, tty_tx, tty_rx).
  localparam logic [31:0] RAM_BASE    = 32'h0000_1000;
  localparam logic [31:0] RAM_MASK    = 32'h0000_F000;
  localparam logic [31:0] STDOUT_BASE = 32'h0000_3000;
  localparam logic [31:0] STDOUT_MASK = 32'h0000_FFFC;
  localparam logic [31:0] STDIN_BASE  = 32'h0000_3004;
  localparam logic [31:0] STDIN_MASK  = 32'h0000_FFFC;

  function automatic logic win_hit(input logic [ADDR_MAX-1:0] addr,
                                   input logic [ADDR_MAX-1:0] base,
                                   input logic [ADDR_MAX-1:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational window decoder: lowest-index matching window wins.
module mmio_addr_decode
  import mmio_bus_pkg::*;
#(
  parameter int unsigned      NS   = 4,
  parameter int unsigned      AW   = 32,
  parameter logic [NS*AW-1:0] BASE = '0,
  parameter logic [NS*AW-1:0] MASK = '0,
  parameter int unsigned      SW   = (NS > 1) ? $clog2(NS) : 1
) (
  input  logic [AW-1:0] addr,
  output logic [SW-1:0] sel,
  output logic          hit
);

  // Priority scan; the !hit guard keeps the first (lowest) match.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int unsigned i = 0; i < NS; i++) begin
      if (!hit && win_hit(ADDR_MAX'(addr),
                          ADDR_MAX'(BASE[i*AW +: AW]),
                          ADDR_MAX'(MASK[i*AW +: AW]))) begin
        sel = SW'(i);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_bus_fabric.sv
// Registered single-master to NS-slave MMIO fabric with unmapped-address error response.
// Optional hung-slave timeout enabled by defining FABRIC_TIMEOUT_EN.
module mmio_bus_fabric
  import mmio_bus_pkg::*;
#(
  parameter int unsigned      NS   = 4,
  parameter int unsigned      AW   = 32,
  parameter int unsigned      DW   = 32,
  parameter logic [NS*AW-1:0] BASE = '0,
  parameter logic [NS*AW-1:0] MASK = '0,
  parameter int unsigned      TMO  = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    addr,
  input  logic [2:0]       size,
  input  logic             valid,
  input  logic             write,
  input  logic [DW-1:0]    wdata,
  output logic [DW-1:0]    rdata,
  output logic             ready,
  output logic             err,
  output logic [NS-1:0]    s_valid,
  output logic [AW-1:0]    s_addr,
  output logic [2:0]       s_size,
  output logic             s_write,
  output logic [DW-1:0]    s_wdata,
  input  logic [NS*DW-1:0] s_rdata,
  input  logic [NS-1:0]    s_ready
);

  localparam int unsigned SW = (NS > 1) ? $clog2(NS) : 1;

  if (TMO < 1 || TMO > 65535) begin : g_tmo_range
    $error("mmio_bus_fabric: TMO must be in 1..65535");
  end

  state_t          state, state_nxt;
  logic [SW-1:0]   dec_sel, sel_q;
  logic            dec_hit;
  logic            take_req;
  logic            slave_done;
  logic            busy_exit;
  logic [AW-1:0]   sel_base;

  mmio_addr_decode #(
    .NS   (NS),
    .AW   (AW),
    .BASE (BASE),
    .MASK (MASK),
    .SW   (SW)
  ) u_decode (
    .addr (addr),
    .sel  (dec_sel),
    .hit  (dec_hit)
  );

  assign sel_base = BASE[dec_sel*AW +: AW];

`ifdef FABRIC_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // BUSY-cycle counter, restarted on every slave request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (take_req && dec_hit) begin
      tmo_cnt <= '0;
    end else if (state == BUSY) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; slave completion is checked before the timeout so it wins a tie.
  always_comb begin
    state_nxt  = state;
    take_req   = 1'b0;
    slave_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (valid) begin
          take_req  = 1'b1;
          state_nxt = dec_hit ? BUSY : RESP;
        end
      end
      BUSY: begin
        if (s_ready[sel_q]) begin
          slave_done = 1'b1;
          state_nxt  = RESP;
        end
`ifdef FABRIC_TIMEOUT_EN
        // Leaving on the count that would reach TMO gives exactly TMO BUSY cycles.
        else if (tmo_cnt == 16'(TMO - 1)) begin
          state_nxt = RESP;
        end
`endif
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_exit = (state == BUSY) && (state_nxt == RESP);

  // Request capture, slave strobe and registered master response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata   <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
      s_valid <= '0;
      s_addr  <= '0;
      s_size  <= '0;
      s_write <= 1'b0;
      s_wdata <= '0;
      sel_q   <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      if (take_req) begin
        s_addr  <= addr - sel_base;
        s_size  <= size;
        s_write <= write;
        s_wdata <= wdata;
        sel_q   <= dec_sel;
        if (dec_hit) begin
          s_valid <= NS'(1) << dec_sel;
        end else begin
          ready <= 1'b1;
          err   <= 1'b1;
          rdata <= '0;
        end
      end
      if (busy_exit) begin
        s_valid <= '0;
        ready   <= 1'b1;
        err     <= !slave_done;
        rdata   <= (slave_done && !s_write) ? s_rdata[sel_q*DW +: DW] : '0;
      end
    end
  end

endmodule
